dbnc_gea1: RTL and testbench

//   Deglitch/debounce filter for the output of a generic gating cell (e.g. an
//   AND2 that combines a raw request with an enable). It samples the gated

---
 rtl/dbnc_gea1.sv | 85 ++++++++
 tb/tb_dbnc_gea1.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dbnc_gea1.sv
`default_nettype none
// ============================================================================
// Module      : dbnc_gea1
// Description : Deglitch/debounce filter for a gated level. y follows the
//               sampled input only after STABLE consecutive differing
//               samples, with one-cycle rise/fall strobes on each change.
//               Optional macro DBNC_GEA1_SYNC_EN inserts a 2-flop
//               synchroniser ahead of the sampler.
// Revision    : 1.0 - initial release
// ============================================================================
module dbnc_gea1 #(
    parameter int CNT_W   = 4,
    parameter int STABLE  = 8,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a,
    output logic y,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STABLE - 1);

    logic             w_s;
    logic             r_y;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;

`ifdef DBNC_GEA1_SYNC_EN
    // a may be asynchronous here; only the second stage feeds the filter
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= RST_VAL;
            r_sync2 <= RST_VAL;
        end else begin
            r_sync1 <= a;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = a;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y    <= RST_VAL;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (en) begin
                if (w_s == r_y) begin
                    r_cnt <= '0;
                end else if (r_cnt == C_LAST) begin
                    // STABLE-th consecutive differing sample: commit the change
                    r_y    <= w_s;
                    r_cnt  <= '0;
                    r_rise <= w_s;
                    r_fall <= ~w_s;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign y    = r_y;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = |r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dbnc_gea1.sv
`default_nettype none
// Testbench for dbnc_gea1: queue-based reference model feeding a scoreboard
// that a free-running monitor drains one entry per clock.
`timescale 1ns/1ps
module tb_dbnc_gea1;

    localparam int CNT_W   = 4;
    localparam int STABLE  = 8;
    localparam bit RST_VAL = 1'b0;

    logic clk = 1'b0;
    logic rst, en, a;
    logic y, rise, fall, busy;

    always #5 clk = ~clk;

    dbnc_gea1 #(
        .CNT_W  (CNT_W),
        .STABLE (STABLE),
        .RST_VAL(RST_VAL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .a   (a),
        .y   (y),
        .rise(rise),
        .fall(fall),
        .busy(busy)
    );

    typedef struct packed {
        logic y;
        logic rise;
        logic fall;
        logic busy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_ex;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: history of enabled samples since the last y change.
    bit m_y;
    bit hist[$];
    bit m_s1, m_s2;

    function automatic int trailing_diff();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != m_y) n++;
            else break;
        end
        return n;
    endfunction

    task automatic drive(input bit r, input bit e, input bit x);
        exp_t ex;
        bit   s;
        int   run;
        rst = r;
        en  = e;
        a   = x;
`ifdef DBNC_GEA1_SYNC_EN
        s = m_s2;
`else
        s = x;
`endif
        if (r) begin
            m_y  = RST_VAL;
            hist.delete();
            m_s1 = RST_VAL;
            m_s2 = RST_VAL;
            ex.y = RST_VAL; ex.rise = 1'b0; ex.fall = 1'b0; ex.busy = 1'b0;
        end else begin
`ifdef DBNC_GEA1_SYNC_EN
            m_s2 = m_s1;
            m_s1 = x;
`endif
            ex.rise = 1'b0;
            ex.fall = 1'b0;
            if (e) begin
                hist.push_back(s);
                if (hist.size() > STABLE) void'(hist.pop_front());
            end
            run = trailing_diff();
            if (e && run >= STABLE) begin
                ex.rise = s;
                ex.fall = !s;
                m_y     = s;
                hist.delete();
                run     = 0;
            end
            ex.y    = m_y;
            ex.busy = (run > 0);
        end
        sb.push_back(ex);
        @(negedge clk);
    endtask

    // Monitor: one expected entry per clock edge, sampled 1ns after it
    always @(posedge clk) begin
        #1;
        cyc++;
        if (sb.size() > 0) begin
            mon_ex = sb.pop_front();
            total++;
            if ({y, rise, fall, busy} !== mon_ex) begin
                bad++;
                $display("FAIL outputs cyc=%0d got y/rise/fall/busy=%b%b%b%b want %b%b%b%b",
                         cyc, y, rise, fall, busy,
                         mon_ex.y, mon_ex.rise, mon_ex.fall, mon_ex.busy);
            end
        end
    end

    initial begin
        int len;
        bit val;
        m_y = RST_VAL; m_s1 = RST_VAL; m_s2 = RST_VAL;

        // reset with a=1 held
        repeat (2) drive(1'b1, 1'b1, 1'b1);
        // clean rise, then clean fall
        repeat (10) drive(1'b0, 1'b1, 1'b1);
        repeat (12) drive(1'b0, 1'b1, 1'b0);
        // glitch one short of STABLE
        repeat (STABLE - 1) drive(1'b0, 1'b1, 1'b1);
        repeat (3) drive(1'b0, 1'b1, 1'b0);
        // enable gap mid-qualification
        repeat (4) drive(1'b0, 1'b1, 1'b1);
        repeat (5) drive(1'b0, 1'b0, 1'b1);
        repeat (6) drive(1'b0, 1'b1, 1'b1);
        repeat (12) drive(1'b0, 1'b1, 1'b0);
        // reset mid-qualification
        repeat (5) drive(1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        repeat (10) drive(1'b0, 1'b1, 1'b1);
        repeat (12) drive(1'b0, 1'b1, 1'b0);

        // randomized runs of random length, occasional en gaps and resets
        for (int seg = 0; seg < 80; seg++) begin
            len = int'($urandom_range(1, 12));
            val = 1'($urandom_range(0, 1));
            repeat (len)
                drive(1'($urandom_range(0, 149) == 0),
                      1'($urandom_range(0, 9) != 0), val);
        end

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
